// File: rtl/patch_moment_acc_pkg.sv
// Shared patch geometry, datapath widths and state encoding for the moment accumulator.
package patch_moment_acc_pkg;

  localparam int PATCH_SIZE   = 31;
  localparam int PATCH_CENTER = 15;
  localparam int COL_SUM_W    = 16;
  localparam int COL_MULT_W   = 20;
  localparam int M00_W        = 18;
  localparam int M10_W        = 21;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/patch_moment_acc.sv
// Accumulates zeroth/first row moments over NCOLS column sums; optional err output with PATCH_ABORT_ERR_EN.
// Latency: m00/m10/out_valid register one cycle after the last column.
// Backpressure: none; every col_valid inside an open patch is consumed.
module patch_moment_acc
  import patch_moment_acc_pkg::*;
#(
  parameter int NCOLS  = PATCH_SIZE,
  parameter int CENTER = PATCH_CENTER
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    patch_start,
  input  logic                    col_valid,
  input  logic [COL_SUM_W-1:0]    col_sum,
  input  logic [COL_MULT_W-1:0]   col_mult,
  output logic                    busy,
  output logic [M00_W-1:0]        m00,
  output logic signed [M10_W-1:0] m10,
  output logic                    out_valid
`ifdef PATCH_ABORT_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam int CNT_W = $clog2(NCOLS + 1);
  localparam logic [CNT_W-1:0] CENTER_C = CNT_W'(CENTER);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(NCOLS - 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         col_cnt, cnt_nxt, base_cnt;
  logic [M00_W-1:0]         acc00, acc00_nxt, base00, m00_nxt;
  logic signed [M10_W-1:0]  acc10, acc10_nxt, base10, m10_nxt, mult_s;
  logic                     take, out_valid_nxt;

  assign busy = (state == ACCUM);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = col_cnt;
    acc00_nxt     = acc00;
    acc10_nxt     = acc10;
    m00_nxt       = m00;
    m10_nxt       = m10;
    out_valid_nxt = 1'b0;
    mult_s        = {{(M10_W-COL_MULT_W){1'b0}}, col_mult};

    // patch_start clears first so a same-cycle column lands as column 0
    base_cnt = patch_start ? '0 : col_cnt;
    base00   = patch_start ? '0 : acc00;
    base10   = patch_start ? '0 : acc10;
    take     = col_valid && (patch_start || state == ACCUM);

    if (patch_start) begin
      state_nxt = ACCUM;
      cnt_nxt   = '0;
      acc00_nxt = '0;
      acc10_nxt = '0;
    end

    if (take) begin
      cnt_nxt   = base_cnt + 1'b1;
      acc00_nxt = base00 + M00_W'(col_sum);
      acc10_nxt = (base_cnt < CENTER_C) ? base10 - mult_s : base10 + mult_s;
      if (base_cnt == LAST_C) begin
        m00_nxt       = acc00_nxt;
        m10_nxt       = acc10_nxt;
        out_valid_nxt = 1'b1;
        state_nxt     = IDLE;
      end
    end
  end

`ifdef PATCH_ABORT_ERR_EN
  logic err_nxt;
  assign err_nxt = (patch_start && state == ACCUM && col_cnt != '0) ||
                   (col_valid && !patch_start && state == IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= '0;
      acc00     <= '0;
      acc10     <= '0;
      m00       <= '0;
      m10       <= '0;
      out_valid <= 1'b0;
`ifdef PATCH_ABORT_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      col_cnt   <= cnt_nxt;
      acc00     <= acc00_nxt;
      acc10     <= acc10_nxt;
      m00       <= m00_nxt;
      m10       <= m10_nxt;
      out_valid <= out_valid_nxt;
`ifdef PATCH_ABORT_ERR_EN
      err       <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_patch_moment_acc.sv
// Table-driven patch vectors with an out_valid scoreboard, plus abort/same-cycle/reset sequences.
module tb_patch_moment_acc;
  import patch_moment_acc_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    patch_start, col_valid;
  logic [COL_SUM_W-1:0]    col_sum;
  logic [COL_MULT_W-1:0]   col_mult;
  logic                    busy, out_valid;
  logic [M00_W-1:0]        m00;
  logic signed [M10_W-1:0] m10;
`ifdef PATCH_ABORT_ERR_EN
  logic                    err;
  int                      err_cnt = 0;
`endif

  patch_moment_acc dut (
    .clk(clk), .rst(rst), .patch_start(patch_start), .col_valid(col_valid),
    .col_sum(col_sum), .col_mult(col_mult), .busy(busy), .m00(m00), .m10(m10),
    .out_valid(out_valid)
`ifdef PATCH_ABORT_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M00_W-1:0]        m00;
    logic signed [M10_W-1:0] m10;
    int                      due;
  } exp_t;

  typedef struct {
    int                      kind;
    int                      gap;
    logic [M00_W-1:0]        m00;
    logic signed [M10_W-1:0] m10;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[5];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ov_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      ov_count++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got m00=%0d m10=%0d, expected no pulse", m00, m10);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("m00", m00, e.m00);
        check("m10", m10, e.m10);
      end
    end
  end

`ifdef PATCH_ABORT_ERR_EN
  always @(negedge clk) if (!rst && err === 1'b1) err_cnt++;
`endif

  task automatic drive(input logic st, input logic v, input int s, input int m);
    @(negedge clk);
    patch_start = st;
    col_valid   = v;
    col_sum     = COL_SUM_W'(s);
    col_mult    = COL_MULT_W'(m);
  endtask

  task automatic col_vals(input int kind, input int c, output int s, output int m);
    int d;
    d = (c > 15) ? c - 15 : 15 - c;
    s = 0;
    m = 0;
    case (kind)
      0: begin s = 100; m = 100 * d; end
      1: if (c > 15) begin s = 7905; m = 7905 * d; end
      2: if (c < 15) begin s = 7905; m = 7905 * d; end
      default: begin s = c + 1; m = (c + 1) * d; end
    endcase
  endtask

  task automatic push_exp(input int e00, input int e10);
    exp_t x;
    x.m00 = M00_W'(e00);
    x.m10 = M10_W'(e10);
    x.due = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    int s, m, base_ov;
`ifdef PATCH_ABORT_ERR_EN
    int base_err;
`endif
    vt[0] = '{0, 0, 18'd3100,   21'sd0};
    vt[1] = '{1, 0, 18'd118575, 21'sd948600};
    vt[2] = '{2, 1, 18'd118575, -21'sd948600};
    vt[3] = '{3, 0, 18'd496,    21'sd2480};
    vt[4] = '{3, 2, 18'd496,    21'sd2480};

    rst = 1'b1; patch_start = 1'b0; col_valid = 1'b0; col_sum = '0; col_mult = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_m00", m00, 0);
    check("rst_m10", m10, 0);
    rst = 1'b0;

    // gap==0 rows start on the previous row's out_valid cycle
    foreach (vt[r]) begin
      drive(1, 0, 0, 0);
      if (vt[r].gap != 0) begin
        drive(0, 0, 0, 0);
        check("busy_open", busy, 1);
      end
      for (int c = 0; c < 31; c++) begin
        col_vals(vt[r].kind, c, s, m);
        drive(0, 1, s, m);
        if (c == 30) push_exp(int'(vt[r].m00), int'(vt[r].m10));
        for (int g = 0; g < vt[r].gap; g++) drive(0, 0, 0, 0);
      end
    end
    drive(0, 0, 0, 0);
    wait_drain("table_drain");
    repeat (3) drive(0, 0, 0, 0);
    check("hold_m00", m00, 496);
    check("hold_m10", m10, 2480);
    check("idle_busy", busy, 0);

    // partial patch discarded by a second patch_start
    base_ov = ov_count;
`ifdef PATCH_ABORT_ERR_EN
    base_err = err_cnt;
`endif
    drive(1, 0, 0, 0);
    for (int c = 0; c < 10; c++) drive(0, 1, 1, (c > 15) ? c - 15 : 15 - c);
    drive(1, 0, 0, 0);
    for (int c = 0; c < 31; c++) begin
      drive(0, 1, 1, (c > 15) ? c - 15 : 15 - c);
      if (c == 30) push_exp(31, 0);
    end
    drive(0, 0, 0, 0);
    wait_drain("abort_drain");
    check("abort_one_pulse", ov_count - base_ov, 1);
`ifdef PATCH_ABORT_ERR_EN
    check("abort_err_once", err_cnt - base_err, 1);
`endif

    // patch_start and column 0 in the same cycle
    drive(1, 1, 5, 0);
    for (int c = 1; c < 31; c++) begin
      drive(0, 1, 5, 0);
      if (c == 30) push_exp(155, 0);
    end
    drive(0, 0, 0, 0);
    wait_drain("same_cycle_drain");

    // reset mid-patch, then columns with no patch_start
    base_ov = ov_count;
    drive(1, 0, 0, 0);
    for (int c = 0; c < 20; c++) drive(0, 1, 3, 3);
    @(negedge clk);
    col_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_m00", m00, 0);
    check("midrst_m10", m10, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 31; c++) drive(0, 1, 9, 9);
    repeat (3) drive(0, 0, 0, 0);
    check("post_rst_no_pulse", ov_count - base_ov, 0);
    check("post_rst_m00", m00, 0);
    check("post_rst_m10", m10, 0);
    check("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/patch_moment_acc.md
PATCH_MOMENT_ACC -- requirements
Module: patch_moment_acc

Interface
REQ-001 The block SHALL have parameter NCOLS, default 31: number of columns per patch.
REQ-002 The block SHALL have parameter CENTER, default 15: column number with zero moment arm.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 patch_start  input  1  one-cycle pulse that opens a new patch.
REQ-006 col_valid  input  1  one-cycle pulse: col_sum and col_mult are valid.
REQ-007 col_sum  input  16  unsigned column pixel sum.
REQ-008 col_mult  input  20  unsigned product of col_sum and the column's distance from CENTER.
REQ-009 busy  output  1  high while a patch is open.
REQ-010 m00  output  18  unsigned zeroth moment (total patch intensity).
REQ-011 m10  output  21  signed first moment along the row axis.
REQ-012 out_valid  output  1  one-cycle pulse: m00 and m10 are updated.

Function
REQ-013 The block SHALL implement two states: IDLE and ACCUM.
REQ-014 IDLE SHALL ignore col_valid and go to ACCUM on patch_start, clearing the accumulators and the column counter col_cnt.
REQ-015 In ACCUM, each col_valid SHALL add col_sum to acc00.
REQ-016 Each col_valid in ACCUM SHALL subtract col_mult from acc10 when col_cnt < CENTER, and add it otherwise (col_cnt == CENTER contributes zero by construction).
REQ-017 Each col_valid in ACCUM SHALL increment col_cnt.
REQ-018 When col_valid arrives with col_cnt == NCOLS-1, m00 and m10 SHALL register the final sums one cycle later, out_valid SHALL pulse one cycle, and the state SHALL return to IDLE.
REQ-019 Latency from the last col_valid to out_valid SHALL be exactly 1 cycle.
REQ-020 patch_start together with col_valid in the same cycle SHALL clear the accumulators and then accept that column as column 0 (col_cnt becomes 1).
REQ-021 patch_start in ACCUM before NCOLS columns SHALL discard the partial patch and restart; no out_valid SHALL be issued for the discarded patch.
REQ-022 patch_start on the out_valid cycle SHALL open the next patch normally.
REQ-023 m00 and m10 SHALL hold their values between out_valid pulses.
REQ-024 busy SHALL equal (state == ACCUM).
REQ-025 acc00 SHALL be 18 bits unsigned; acc10 SHALL be 21 bits signed with col_mult zero-extended before add/subtract; with NCOLS=31 neither SHALL overflow.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, col_cnt=0, acc00=0, acc10=0, m00=0, m10=0, out_valid=0, busy=0.
REQ-027 rst asserted mid-patch SHALL abort the patch with no out_valid after release.
REQ-028 After reset release, the block SHALL take no column until the next patch_start.

Configuration
REQ-029 With PATCH_ABORT_ERR_EN defined, the block SHALL add output err (1 bit, reset 0).
REQ-030 err SHALL pulse one cycle when patch_start discards a partial patch (col_cnt > 0 in ACCUM), or when col_valid arrives in IDLE without patch_start.
REQ-031 Without PATCH_ABORT_ERR_EN, the err port and its logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-032 The shared package/header SHALL hold the constants PATCH_SIZE=31, PATCH_CENTER=15, COL_SUM_W=16, COL_MULT_W=20, M00_W=18 and M10_W=21; the parameter defaults SHALL derive from them.
REQ-033 The block SHALL be a single module with no sub-module; the state machine and accumulators are in one clocked process.

Verification
REQ-034 Bench: patch_start, then 31 columns with col_sum=100 and col_mult=100*|c-15| -> out_valid 1 cycle after column 30, m00=3100, m10=0.
REQ-035 Bench: a patch with only columns 16..30 nonzero (col_sum=7905, col_mult=7905*(c-15)) -> m00=118575, m10=+948600.
REQ-036 Bench: a patch with only columns 0..14 nonzero (same magnitudes) -> m10=-948600.
REQ-037 Bench: patch_start after 10 columns, then 31 columns of col_sum=1 -> exactly one out_valid with m00=31; err pulses once when PATCH_ABORT_ERR_EN is defined.
REQ-038 Bench: patch_start and col_valid in the same cycle (col_sum=5), then 30 more columns of col_sum=5 -> m00=155.
REQ-039 Bench: rst asserted at column 20 and released, then col_valid pulses without patch_start -> no out_valid, m00=m10=0, busy=0.
